// File: rtl/casl_oracle_query_ctrl.sv
// casl_oracle_query_ctrl
// Oracle/query front-end for the CAS-Lock protected c1908 netlist.
// The controller loads the key serially into a shadow register and commits it
// to dut_key in a single cycle. It then applies query patterns, waits a settle
// time and returns the sampled G75 output.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// KEY_EMPTY | no key committed since reset; only key bits accepted
// KEY_LOAD  | shifting a key into the shadow; dut_key still holds the old key
// READY     | key committed; a query or the first bit of a reload is accepted
// APPLY     | pattern on dut_pi, settle_cnt counting down to the sample point
// RESP      | r_data/r_valid held until the consumer takes the response
module casl_oracle_query_ctrl #(
  parameter int KEY_W      = 64,
  parameter int PI_W       = 33,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kin_valid,
  input  logic             kin_bit,
  output logic             kin_ready,
  output logic             key_loaded,
  input  logic             q_valid,
  input  logic [PI_W-1:0]  q_pattern,
  output logic             q_ready,
  output logic             r_valid,
  output logic             r_data,
  input  logic             r_ready,
  output logic [PI_W-1:0]  dut_pi,
  output logic [KEY_W-1:0] dut_key,
  input  logic             dut_out,
  output logic [CNT_W-1:0] query_cnt
);

  localparam int BIT_W = $clog2(KEY_W + 1);

  typedef enum logic [2:0] {
    KEY_EMPTY,
    KEY_LOAD,
    READY,
    APPLY,
    RESP
  } state_t;

  state_t             state;
  // The shadow holds KEY_W-1 bits. The final bit goes straight from kin_bit
  // into the committed key, so a shift would push only the oldest bit out.
  logic [KEY_W-2:0]   key_shadow;
  logic [BIT_W-1:0]   bit_cnt;
  logic [3:0]         settle_cnt;

  logic               key_xfer;
  logic               q_xfer;
  logic               last_bit;
  logic [KEY_W-2:0]   shadow_next;

  // Handshake readiness; a pending query blocks key bits in READY.
  always_comb begin
    kin_ready = (state == KEY_EMPTY) || (state == KEY_LOAD) ||
                ((state == READY) && !q_valid);
    q_ready   = (state == READY);
  end

  // Transfer qualifiers and the next shadow value.
  always_comb begin
    key_xfer    = kin_valid && kin_ready;
    q_xfer      = q_valid && q_ready;
    last_bit    = (bit_cnt == BIT_W'(KEY_W - 1));
    shadow_next = {kin_bit, key_shadow[KEY_W-2:1]};
  end

  // Main sequencer: key shift/commit, query apply, settle countdown, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= KEY_EMPTY;
      key_shadow <= '0;
      dut_key    <= '0;
      dut_pi     <= '0;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      query_cnt  <= '0;
      r_data     <= 1'b0;
      r_valid    <= 1'b0;
      key_loaded <= 1'b0;
    end else begin
      case (state)
        KEY_EMPTY, READY: begin
          if (q_xfer) begin
            dut_pi     <= q_pattern;
            settle_cnt <= 4'(SETTLE_CYC - 1);
            state      <= APPLY;
          end else if (key_xfer) begin
            key_shadow <= shadow_next;
            bit_cnt    <= BIT_W'(1);
            key_loaded <= 1'b0;
            state      <= KEY_LOAD;
          end
        end
        KEY_LOAD: begin
          if (key_xfer) begin
            key_shadow <= shadow_next;
            if (last_bit) begin
              dut_key    <= {kin_bit, key_shadow};
              key_loaded <= 1'b1;
              bit_cnt    <= '0;
              state      <= READY;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        APPLY: begin
          if (settle_cnt == 4'd0) begin
            r_data  <= dut_out;
            r_valid <= 1'b1;
            state   <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RESP: begin
          if (r_ready) begin
            r_valid   <= 1'b0;
            query_cnt <= query_cnt + CNT_W'(1);
            state     <= READY;
          end
        end
        default: state <= KEY_EMPTY;
      endcase
    end
  end

  // Settle time must fit the 4-bit countdown and be at least one cycle.
  always_ff @(posedge clk) begin
    a_settle_range: assert (SETTLE_CYC >= 1 && SETTLE_CYC <= 15);
  end

endmodule

// File: tb/tb_casl_oracle_query_ctrl.sv
// tb_casl_oracle_query_ctrl
// Directed bench. The stimulus process pushes the expected r_data of each
// query into a scoreboard queue. A monitor pops the queue on every response
// handshake and compares the value.
module tb_casl_oracle_query_ctrl;

  localparam int KEY_W = 64;
  localparam int PI_W  = 33;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             kin_valid;
  logic             kin_bit;
  logic             kin_ready;
  logic             key_loaded;
  logic             q_valid;
  logic [PI_W-1:0]  q_pattern;
  logic             q_ready;
  logic             r_valid;
  logic             r_data;
  logic             r_ready;
  logic [PI_W-1:0]  dut_pi;
  logic [KEY_W-1:0] dut_key;
  logic             dut_out;
  logic [CNT_W-1:0] query_cnt;

  int checks   = 0;
  int failures = 0;
  int n_resp   = 0;
  logic exp_q[$];

  logic [KEY_W-1:0] key_a;
  logic [KEY_W-1:0] key_b;

  casl_oracle_query_ctrl #(
    .KEY_W(KEY_W), .PI_W(PI_W), .SETTLE_CYC(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .kin_valid(kin_valid), .kin_bit(kin_bit), .kin_ready(kin_ready),
    .key_loaded(key_loaded),
    .q_valid(q_valid), .q_pattern(q_pattern), .q_ready(q_ready),
    .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
    .dut_pi(dut_pi), .dut_key(dut_key), .dut_out(dut_out),
    .query_cnt(query_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every accepted response against the scoreboard.
  always @(negedge clk) begin
    if (!rst && r_valid && r_ready) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 64'(r_valid), 64'd0);
      end else begin
        chk("resp_data", 64'(r_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_kin_ready"}, 64'(kin_ready), 64'd1);
    chk({tag, "_key_loaded"}, 64'(key_loaded), 64'd0);
    chk({tag, "_r_valid"}, 64'(r_valid), 64'd0);
    chk({tag, "_r_data"}, 64'(r_data), 64'd0);
    chk({tag, "_q_ready"}, 64'(q_ready), 64'd0);
    chk({tag, "_dut_key"}, dut_key, 64'd0);
    chk({tag, "_dut_pi"}, 64'(dut_pi), 64'd0);
    chk({tag, "_query_cnt"}, 64'(query_cnt), 64'd0);
  endtask

  task automatic load_key(input logic [KEY_W-1:0] k, input string tag);
    int qr_bad;
    qr_bad = 0;
    kin_valid = 1'b1;
    for (int i = 0; i < KEY_W; i++) begin
      kin_bit = k[i];
      if (q_ready !== 1'b0) qr_bad++;
      if (i == KEY_W - 1) chk({tag, "_no_early_commit"}, 64'(key_loaded), 64'd0);
      step();
    end
    kin_valid = 1'b0;
    chk({tag, "_q_ready_during_load"}, 64'(qr_bad), 64'd0);
    chk({tag, "_key_loaded"}, 64'(key_loaded), 64'd1);
    chk({tag, "_dut_key"}, dut_key, k);
  endtask

  initial begin
    int bad;
    key_a = 64'hA5A5_0F0F_3C3C_FFFF;
    key_b = 64'h0123_4567_89AB_CDEF;
    rst = 1'b1; kin_valid = 1'b0; kin_bit = 1'b0; q_valid = 1'b0;
    q_pattern = '0; r_ready = 1'b1; dut_out = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check_reset_outputs("reset");

    // Initial key load.
    load_key(key_a, "load_a");

    // Basic query, expected response 1.
    q_pattern = 33'h1_2345_6789; q_valid = 1'b1; dut_out = 1'b1;
    exp_q.push_back(1'b1);
    step();                                      // T+1
    q_valid = 1'b0;
    chk("q1_dut_pi", 64'(dut_pi), 64'h1_2345_6789);
    chk("q1_q_ready_apply", 64'(q_ready), 64'd0);
    step();                                      // T+2
    chk("q1_r_valid_early", 64'(r_valid), 64'd0);
    step();                                      // T+3
    chk("q1_r_valid", 64'(r_valid), 64'd1);
    chk("q1_r_data", 64'(r_data), 64'd1);
    step();                                      // T+4
    chk("q1_query_cnt", 64'(query_cnt), 64'd1);
    chk("q1_r_valid_drop", 64'(r_valid), 64'd0);

    // Backpressure: sampled value 0, dut_out toggles while r_ready is low.
    r_ready = 1'b0; dut_out = 1'b0;
    q_pattern = 33'h0_DEAD_BEEF; q_valid = 1'b1;
    exp_q.push_back(1'b0);
    step(); q_valid = 1'b0;
    step(); step();                              // T+3, in RESP
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      dut_out = ~dut_out;
      #1;
      if (r_valid !== 1'b1 || r_data !== 1'b0 || q_ready !== 1'b0 || kin_ready !== 1'b0) bad++;
      step();
    end
    chk("bp_hold_violations", 64'(bad), 64'd0);
    r_ready = 1'b1;
    step();
    chk("bp_query_cnt", 64'(query_cnt), 64'd2);
    chk("bp_q_ready_after", 64'(q_ready), 64'd1);

    // Conflict in READY: the query wins; the key bit (first bit of key_b) waits.
    kin_valid = 1'b1; kin_bit = key_b[0];
    q_valid = 1'b1; q_pattern = 33'h1_0F0F_0F0F; dut_out = 1'b1;
    #1;
    chk("cf_kin_ready", 64'(kin_ready), 64'd0);
    chk("cf_q_ready", 64'(q_ready), 64'd1);
    exp_q.push_back(1'b1);
    step();                                      // T+1
    q_valid = 1'b0;
    chk("cf_dut_pi", 64'(dut_pi), 64'h1_0F0F_0F0F);
    step(); step();                              // T+3, response taken
    chk("cf_key_kept_resp", 64'(key_loaded), 64'd1);
    step();                                      // T+4, READY
    chk("cf_query_cnt", 64'(query_cnt), 64'd3);
    chk("cf_key_not_consumed", 64'(key_loaded), 64'd1);
    chk("cf_kin_ready_after", 64'(kin_ready), 64'd1);
    step();                                      // first bit of reload taken
    chk("rl_key_loaded_drop", 64'(key_loaded), 64'd0);
    chk("rl_old_key_after_first", dut_key, key_a);

    // Reload bits 1..63 with a query waiting from bit 10 on.
    bad = 0;
    for (int i = 1; i < KEY_W; i++) begin
      kin_bit = key_b[i];
      if (i == 10) begin
        q_valid = 1'b1; q_pattern = 33'h0_5555_AAAA;
      end
      #1;
      if (q_ready !== 1'b0 || dut_key !== key_a) bad++;
      step();
    end
    kin_valid = 1'b0;
    chk("rl_stall_violations", 64'(bad), 64'd0);
    chk("rl_key_loaded", 64'(key_loaded), 64'd1);
    chk("rl_dut_key", dut_key, key_b);
    chk("rl_q_ready", 64'(q_ready), 64'd1);
    dut_out = 1'b0;
    exp_q.push_back(1'b0);
    step();                                      // stalled query accepted
    q_valid = 1'b0;
    chk("rl_dut_pi", 64'(dut_pi), 64'h0_5555_AAAA);
    step(); step(); step();
    chk("rl_query_cnt", 64'(query_cnt), 64'd4);
    chk("rl_dut_pi_hold", 64'(dut_pi), 64'h0_5555_AAAA);

    // Reset during APPLY: no response, everything back to reset values.
    q_valid = 1'b1; q_pattern = 33'h1_FFFF_0000; dut_out = 1'b1;
    step();                                      // in APPLY
    q_valid = 1'b0;
    rst = 1'b1;
    step();
    check_reset_outputs("rst_apply");
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (r_valid !== 1'b0) bad++;
      step();
    end
    chk("rst_no_r_valid", 64'(bad), 64'd0);

    // Wrap of query_cnt.
    load_key(key_a, "load_c");
    force dut.query_cnt = 16'hFFFF;
    step();
    release dut.query_cnt;
    #1;
    chk("wrap_preload", 64'(query_cnt), 64'hFFFF);
    q_valid = 1'b1; q_pattern = 33'h0_0000_0001; dut_out = 1'b1;
    exp_q.push_back(1'b1);
    step();
    q_valid = 1'b0;
    step(); step(); step();
    chk("wrap_query_cnt", 64'(query_cnt), 64'd0);

    step();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("resp_count", 64'(n_resp), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
